// File: rtl/block_led_sang_dan_tat_dan_pkg.sv
// Shared constants and the step-to-LED pattern mapping
// for the fill/drain LED chaser.
package block_led_sang_dan_tat_dan_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 25_000_000;
    localparam int unsigned STEP_COUNT      = 16;
    localparam int unsigned FULL_STEP       = 8;
    localparam int unsigned LED_WIDTH       = 8;
    localparam int unsigned STEP_W          = 4;
    localparam int unsigned CNT_W           = 32;

    typedef logic [STEP_W-1:0]    step_t;
    typedef logic [LED_WIDTH-1:0] led_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    localparam step_t LAST_STEP = step_t'(STEP_COUNT - 1);
    localparam step_t FULL_IDX  = step_t'(FULL_STEP);

    // Steps up to FULL_STEP light LEDs from bit 0 upward; later steps
    // extinguish them starting again from bit 0.
    function automatic led_t led_pattern(input step_t s);
        led_t all_on;
        all_on = '1;
        if (s <= FULL_IDX) begin
            return ~(all_on << s);
        end
        return all_on << (s - FULL_IDX);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running divider that pulses tick for one clock
// every CLK_DIV clocks.
module led_tick_gen
    import block_led_sang_dan_tat_dan_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk_50M,
    input  logic reset,
    output logic tick
);

    localparam cnt_t LAST = cnt_t'(CLK_DIV - 1);

    cnt_t count_q = '0;
    cnt_t count_d;

    always_comb begin
        tick    = (count_q == LAST);
        count_d = tick ? '0 : count_q + cnt_t'(1);
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/block_led_sang_dan_tat_dan.sv
// LED chaser: lights 8 LEDs one by one, then turns them off
// in the same order, one step per CLK_DIV clocks.
module block_led_sang_dan_tat_dan
    import block_led_sang_dan_tat_dan_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 clk_50M,
    input  logic                 reset,
    output logic [LED_WIDTH-1:0] out
);

    logic  tick;
    step_t s_q   = '0;
    step_t s_d;
    led_t  out_q = '0;
    led_t  out_d;

    led_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_50M (clk_50M),
        .reset   (reset),
        .tick    (tick)
    );

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            s_q   <= '0;
            out_q <= '0;
        end else begin
            s_q   <= s_d;
            out_q <= out_d;
        end
    end

    always_comb begin
        s_d = s_q;
        if (tick) begin
            s_d = (s_q == LAST_STEP) ? '0 : s_q + step_t'(1);
        end
    end

    // Pattern is taken from the next step so out moves on the tick edge.
    always_comb begin
        out_d = out_q;
        if (tick) begin
            out_d = led_pattern(s_d);
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_block_led_sang_dan_tat_dan.sv
// Directed bench: CLK_DIV=4 and CLK_DIV=1 instances
// checked against a hand-written 16-step table.
module tb_block_led_sang_dan_tat_dan;

    typedef struct {
        int         step;
        logic [7:0] led;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst4 = 1'b0;
    logic       rst1 = 1'b0;
    logic [7:0] out4;
    logic [7:0] out1;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs [16];

    always #5 clk = ~clk;

    block_led_sang_dan_tat_dan #(.CLK_DIV(4)) dut4 (
        .clk_50M (clk),
        .reset   (rst4),
        .out     (out4)
    );

    block_led_sang_dan_tat_dan #(.CLK_DIV(1)) dut1 (
        .clk_50M (clk),
        .reset   (rst1),
        .out     (out1)
    );

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %02h, want %02h", name, idx, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{0,  8'h00};
        vecs[1]  = '{1,  8'h01};
        vecs[2]  = '{2,  8'h03};
        vecs[3]  = '{3,  8'h07};
        vecs[4]  = '{4,  8'h0F};
        vecs[5]  = '{5,  8'h1F};
        vecs[6]  = '{6,  8'h3F};
        vecs[7]  = '{7,  8'h7F};
        vecs[8]  = '{8,  8'hFF};
        vecs[9]  = '{9,  8'hFE};
        vecs[10] = '{10, 8'hFC};
        vecs[11] = '{11, 8'hF8};
        vecs[12] = '{12, 8'hF0};
        vecs[13] = '{13, 8'hE0};
        vecs[14] = '{14, 8'hC0};
        vecs[15] = '{15, 8'h80};

        // power-up state, no reset ever applied
        #1;
        check("powerup4", 0, out4, 8'h00);
        check("powerup1", 0, out1, 8'h00);

        // three full CLK_DIV=4 cycles; 12 full CLK_DIV=1 cycles
        for (int n = 1; n <= 192; n++) begin
            @(posedge clk);
            #1;
            check("div4_seq", n, out4, vecs[(n / 4) % 16].led);
            check("div1_seq", n, out1, vecs[n % 16].led);
            if (n % 64 == 0) begin
                check("div4_wrap", n, out4, 8'h00);
            end
        end

        // walk to step 5 (1F) again
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            check("pre_rst", i, out4, vecs[i / 4].led);
        end
        check("at_step5", 5, out4, 8'h1F);

        // assert reset between edges, mid-step
        @(posedge clk);
        #3;
        check("mid_step", 5, out4, 8'h1F);
        rst4 = 1'b1;
        #1;
        check("async_rst", 0, out4, 8'h00);

        // hold reset for 20 clocks
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold", i, out4, 8'h00);
        end
        @(negedge clk);
        rst4 = 1'b0;

        // first step lands on the 4th edge after release
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            check("post_rst", i, out4, vecs[i / 4].led);
        end

        // short reset pulse on the CLK_DIV=1 instance, no edge inside
        @(negedge clk);
        rst1 = 1'b1;
        #1;
        check("div1_async", 0, out1, 8'h00);
        #2;
        rst1 = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            check("div1_post", i, out1, vecs[i % 16].led);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/block_led_sang_dan_tat_dan.md
BLOCK_LED_SANG_DAN_TAT_DAN -- requirements
Module: block_led_sang_dan_tat_dan

Interface
REQ-001 Parameter CLK_DIV, default 25_000_000, meaning clk_50M cycles per pattern step (0.5 s at 50 MHz); legal range 1 to 2^32-1.
REQ-002 Port clk_50M  input  1  single system clock, all logic on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port out  output  8  LED drive, bit 0 = first LED, 1 = LED on; driven directly from a register.

Function
REQ-005 The block SHALL contain a step-tick counter (32-bit) counting 0..CLK_DIV-1 and wrapping to 0.
- tick is asserted for exactly one cycle when count == CLK_DIV-1.
REQ-006 With CLK_DIV = 1, tick SHALL be asserted every cycle.
REQ-007 The block SHALL hold a 4-bit step index s, 0..15, advancing by 1 on each tick and wrapping from 15 to 0.
REQ-008 out SHALL be registered and update on the same clock edge as the step advance.
REQ-009 Fill phase: for s = 0..8, out SHALL equal the lower s bits set: 00, 01, 03, 07, 0F, 1F, 3F, 7F, FF (hex).
REQ-010 Drain phase: for s = 9..15, out SHALL equal FF shifted left by (s-8): FE, FC, F8, F0, E0, C0, 80.
- Drain clears LEDs in the same order the fill phase lit them.
REQ-011 After s = 15 (out = 80), the next tick SHALL return to s = 0 (out = 00); the full cycle is 16 ticks = 16*CLK_DIV clocks.
REQ-012 Each value of out SHALL be stable for exactly CLK_DIV clocks.
- Exception: the first value after reset release, which also lasts exactly CLK_DIV clocks.
REQ-013 No other output values SHALL ever appear; there are no glitches between steps.

Reset
REQ-014 While reset is high, count, s and out SHALL be 0, asynchronously and regardless of clock.
REQ-015 Reset asserted mid-pattern SHALL abort immediately to out = 00.
- After release, the first tick occurs CLK_DIV rising edges later and gives out = 01.
REQ-016 All registers SHALL have power-up initial values equal to their reset values.
- The pattern therefore runs correctly from time 0 even if reset is never asserted.

Structure
REQ-017 A shared package SHALL hold:
- default CLK_DIV;
- STEP_COUNT = 16 and FULL_STEP = 8;
- LED_WIDTH = 8.
REQ-018 The tick counter SHALL be one sub-module, led_tick_gen.
- Ports: clock, reset, parameter CLK_DIV, output tick.
- The top holds the step index and out register.

Verification
REQ-019 Benches SHALL use CLK_DIV = 4 unless stated otherwise.
REQ-020 Scenario 1: reset=0 from time 0, no reset pulse, 16*4 clocks.
- out SHALL read 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80, each for 4 clocks.
- Then 00 again.
REQ-021 Scenario 2: assert reset at step 5 (out = 1F) between clock edges.
- out = 00 immediately, without a clock edge.
- After release, out = 01 at the 4th rising edge.
REQ-022 Scenario 3: CLK_DIV = 1.
- out changes every clock through the 16-value sequence.
- Sequence period is 16 clocks.
REQ-023 Scenario 4: hold reset high for 20 clocks.
- out stays 00 throughout.
- Counter does not advance; the first step occurs exactly CLK_DIV clocks after release.
REQ-024 Scenario 5: run 3 full cycles (192 clocks).
- The sequence repeats identically each cycle.
- No value outside the 16-entry table ever appears.
- Wrap 80 -> 00 occurs at clocks 64, 128 and 192.
